// File: rtl/shake_pkg.sv
// Shared definitions for the SHAKE sponge control path: FSM state encoding and
// default sizing used by the load stage, the controller and the datapath.
package shake_pkg;
   localparam int NUM_ROUNDS_DEF = 24;
   localparam int CNT_W_DEF      = 16;
   localparam int IDX_W          = 5;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PERMUTE = 2'd1,
      SQUEEZE = 2'd2
   } state_t;
endpackage

// File: rtl/round_counter.sv
// Keccak round index counter. Saturates at the last round so the index holds
// its value once the permutation is over.
module round_counter
   import shake_pkg::*;
#(
   parameter int NUM_ROUNDS = NUM_ROUNDS_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clr,
   input  logic             i_en,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_tc
);

   logic [IDX_W-1:0] r_idx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                r_idx <= '0;
      else if (i_clr)         r_idx <= '0;
      else if (i_en && !o_tc) r_idx <= r_idx + IDX_W'(1);
   end

   assign o_idx = r_idx;
   assign o_tc  = (r_idx == IDX_W'(NUM_ROUNDS - 1));

endmodule

// File: rtl/absorb_squeeze_fsm.sv
// Sponge controller: absorbs buffered rate blocks, runs Keccak-f rounds and
// hands out the requested number of squeeze blocks.
module absorb_squeeze_fsm
   import shake_pkg::*;
#(
   parameter int NUM_ROUNDS = NUM_ROUNDS_DEF,
   parameter int CNT_W      = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_buf_full,
   input  logic             i_buf_last,
   input  logic [CNT_W-1:0] i_out_blocks,
   input  logic             i_out_ready,
   output logic             o_buf_clear,
   output logic             o_absorb_en,
   output logic             o_round_en,
   output logic [IDX_W-1:0] o_round_idx,
   output logic             o_state_clear,
   output logic             o_out_valid,
   output logic             o_out_last,
   output logic             o_busy
);

   state_t           r_state, w_next;
   logic [CNT_W-1:0] r_remaining;
   logic             r_first_flag;
   logic             r_last_flag;
   logic             w_tc;
   logic             w_rem_gt1;
   logic             w_rc_clr;

   assign w_rem_gt1 = (r_remaining > CNT_W'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (i_buf_full)  w_next = PERMUTE;
         PERMUTE: if (w_tc)        w_next = r_last_flag ? SQUEEZE : IDLE;
         SQUEEZE: if (i_out_ready) w_next = w_rem_gt1 ? PERMUTE : IDLE;
         default:                  w_next = IDLE;
      endcase
   end

   // Everything is forced low while reset is held, including the IDLE absorb path.
   always_comb begin
      o_buf_clear   = 1'b0;
      o_absorb_en   = 1'b0;
      o_round_en    = 1'b0;
      o_state_clear = 1'b0;
      o_out_valid   = 1'b0;
      o_out_last    = 1'b0;
      o_busy        = 1'b0;
      if (!rst) begin
         o_busy = (r_state != IDLE);
         case (r_state)
            IDLE: begin
               o_absorb_en = i_buf_full;
               o_buf_clear = i_buf_full;
            end
            PERMUTE: o_round_en = 1'b1;
            SQUEEZE: begin
               o_out_valid   = 1'b1;
               o_out_last    = !w_rem_gt1;
               o_state_clear = i_out_ready && !w_rem_gt1;
            end
            default: ;
         endcase
      end
   end

   // Block count is taken only from a message's first block.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_remaining  <= '0;
         r_first_flag <= 1'b1;
         r_last_flag  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (i_buf_full) begin
               r_last_flag <= i_buf_last;
               if (r_first_flag) begin
                  r_remaining  <= (i_out_blocks == '0) ? CNT_W'(1) : i_out_blocks;
                  r_first_flag <= 1'b0;
               end
            end
            SQUEEZE: if (i_out_ready) begin
               if (w_rem_gt1) begin
                  r_remaining <= r_remaining - CNT_W'(1);
               end else begin
                  r_first_flag <= 1'b1;
                  r_last_flag  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign w_rc_clr = o_absorb_en || (r_state == SQUEEZE && i_out_ready && w_rem_gt1);

   round_counter #(.NUM_ROUNDS(NUM_ROUNDS)) u_round_counter (
      .clk   (clk),
      .rst   (rst),
      .i_clr (w_rc_clr),
      .i_en  (o_round_en),
      .o_idx (o_round_idx),
      .o_tc  (w_tc)
   );

endmodule

// File: tb/tb_absorb_squeeze_fsm.sv
// Bench for absorb_squeeze_fsm: directed cycle tables for the message scenarios,
// then randomized traffic against a message-level reference model.
module tb_absorb_squeeze_fsm;
   localparam int NR = 24;

   localparam logic [6:0] CLR = 7'b1000000;
   localparam logic [6:0] ABS = 7'b0100000;
   localparam logic [6:0] RND = 7'b0010000;
   localparam logic [6:0] SCL = 7'b0001000;
   localparam logic [6:0] OV  = 7'b0000100;
   localparam logic [6:0] OL  = 7'b0000010;
   localparam logic [6:0] BSY = 7'b0000001;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_buf_full, i_buf_last, i_out_ready;
   logic [15:0] i_out_blocks;
   logic        o_buf_clear, o_absorb_en, o_round_en, o_state_clear;
   logic        o_out_valid, o_out_last, o_busy;
   logic [4:0]  o_round_idx;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   absorb_squeeze_fsm dut (
      .clk           (clk),
      .rst           (rst),
      .i_buf_full    (i_buf_full),
      .i_buf_last    (i_buf_last),
      .i_out_blocks  (i_out_blocks),
      .i_out_ready   (i_out_ready),
      .o_buf_clear   (o_buf_clear),
      .o_absorb_en   (o_absorb_en),
      .o_round_en    (o_round_en),
      .o_round_idx   (o_round_idx),
      .o_state_clear (o_state_clear),
      .o_out_valid   (o_out_valid),
      .o_out_last    (o_out_last),
      .o_busy        (o_busy)
   );

   typedef struct {
      string      nm;
      bit         r, f, l;
      int         ob;
      bit         rdy;
      int         reps;
      logic [6:0] e;
      int         idx;
      bit         inc;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input string nm, input bit r, input bit f, input bit l, input int ob,
                      input bit rdy, input int reps, input logic [6:0] e, input int idx,
                      input bit inc);
      vec_t v;
      v.nm = nm; v.r = r; v.f = f; v.l = l; v.ob = ob; v.rdy = rdy;
      v.reps = reps; v.e = e; v.idx = idx; v.inc = inc;
      tbl.push_back(v);
   endtask

   function automatic logic [6:0] act_vec();
      return {o_buf_clear, o_absorb_en, o_round_en, o_state_clear, o_out_valid, o_out_last, o_busy};
   endfunction

   task automatic check(input string nm, input logic [6:0] e, input int ei);
      logic [6:0] a;
      a = act_vec();
      total++;
      if (a !== e || int'(o_round_idx) != ei) begin
         bad++;
         $display("FAIL %s t=%0t: got out=%b idx=%0d, want out=%b idx=%0d",
                  nm, $time, a, o_round_idx, e, ei);
      end
   endtask

   task automatic drive(input bit r, input bit f, input bit l, input int ob, input bit rdy);
      rst = r; i_buf_full = f; i_buf_last = l; i_out_blocks = 16'(ob); i_out_ready = rdy;
   endtask

   // Reference model: tracks the message as phases (permuting a round, waiting
   // on a squeeze block) with a count of squeeze blocks still owed.
   bit m_perm, m_sq, m_first, m_last;
   int m_r, m_rem;

   task automatic model_reset();
      m_perm = 0; m_sq = 0; m_first = 1; m_last = 0; m_r = 0; m_rem = 0;
   endtask

   task automatic model_eval(input bit r, input bit f, input bit rdy,
                             output logic [6:0] e, output int ei);
      e = '0;
      ei = m_r;
      if (!r) begin
         if (!m_perm && !m_sq && f) e |= CLR | ABS;
         if (m_perm) e |= RND | BSY;
         if (m_sq) begin
            e |= OV | BSY;
            if (m_rem == 1) e |= OL;
            if (m_rem == 1 && rdy) e |= SCL;
         end
      end
   endtask

   task automatic model_step(input bit f, input bit l, input int ob, input bit rdy);
      if (!m_perm && !m_sq) begin
         if (f) begin
            m_last = l;
            if (m_first) begin
               m_rem = (ob == 0) ? 1 : ob;
               m_first = 0;
            end
            m_r = 0;
            m_perm = 1;
         end
      end else if (m_perm) begin
         if (m_r == NR - 1) begin
            m_perm = 0;
            m_sq = m_last;
         end else m_r++;
      end else if (rdy) begin
         m_sq = 0;
         if (m_rem > 1) begin
            m_rem--; m_r = 0; m_perm = 1;
         end else begin
            m_first = 1; m_last = 0;
         end
      end
   endtask

   initial begin
      drive(1, 0, 0, 0, 0);
      // nm, rst, full, last, out_blocks, ready, reps, expected, idx, idx increments
      add("reset",        1, 0, 0, 0, 0,  2, '0,                 0, 0);
      add("m1_absorb",    0, 1, 1, 1, 0,  1, CLR|ABS,            0, 0);
      add("m1_perm",      0, 0, 0, 1, 0, NR, RND|BSY,            0, 1);
      add("m1_stall",     0, 0, 0, 1, 0, 10, OV|OL|BSY,         23, 0);
      add("m1_take",      0, 0, 0, 1, 1,  1, SCL|OV|OL|BSY,     23, 0);
      add("m1_idle",      0, 0, 0, 1, 0,  2, '0,                23, 0);
      add("m2_absorb_ob0",0, 1, 1, 0, 0,  1, CLR|ABS,           23, 0);
      add("m2_perm",      0, 0, 0, 0, 0, NR, RND|BSY,            0, 1);
      add("m2_take",      0, 0, 0, 0, 1,  1, SCL|OV|OL|BSY,     23, 0);
      add("m2_idle",      0, 0, 0, 0, 0,  1, '0,                23, 0);
      add("m3_absorb1",   0, 1, 0, 2, 0,  1, CLR|ABS,           23, 0);
      add("m3_perm1",     0, 0, 0, 2, 0, NR, RND|BSY,            0, 1);
      add("m3_idle1",     0, 0, 0, 2, 0,  1, '0,                23, 0);
      add("m3_absorb2",   0, 1, 0, 2, 0,  1, CLR|ABS,           23, 0);
      add("m3_perm2_full",0, 1, 1, 2, 0, NR, RND|BSY,            0, 1);
      add("m3_absorb3",   0, 1, 1, 2, 0,  1, CLR|ABS,           23, 0);
      add("m3_perm3",     0, 0, 0, 2, 0, NR, RND|BSY,            0, 1);
      add("m3_sq1",       0, 0, 0, 2, 1,  1, OV|BSY,            23, 0);
      add("m3_perm4",     0, 0, 0, 2, 0, NR, RND|BSY,            0, 1);
      add("m3_sq2_full",  0, 1, 1, 1, 1,  1, SCL|OV|OL|BSY,     23, 0);
      add("m3b_nobubble", 0, 1, 1, 1, 0,  1, CLR|ABS,           23, 0);
      add("m3b_perm",     0, 0, 0, 1, 0, NR, RND|BSY,            0, 1);
      add("m3b_take",     0, 0, 0, 1, 1,  1, SCL|OV|OL|BSY,     23, 0);
      add("m4_absorb_ob3",0, 1, 1, 3, 0,  1, CLR|ABS,           23, 0);
      add("m4_perm_part", 0, 0, 0, 3, 0, 11, RND|BSY,            0, 1);
      add("m4_rst_r11",   1, 0, 0, 3, 0,  1, '0,                 0, 0);
      add("m4_new_absorb",0, 1, 1, 1, 0,  1, CLR|ABS,            0, 0);
      add("m4_perm",      0, 0, 0, 1, 0, NR, RND|BSY,            0, 1);
      add("m4_take",      0, 0, 0, 1, 1,  1, SCL|OV|OL|BSY,     23, 0);
      add("m4_idle",      0, 0, 0, 1, 0,  1, '0,                23, 0);

      @(posedge clk); #1;
      foreach (tbl[i]) begin
         for (int k = 0; k < tbl[i].reps; k++) begin
            drive(tbl[i].r, tbl[i].f, tbl[i].l, tbl[i].ob, tbl[i].rdy);
            #4;
            check(tbl[i].nm, tbl[i].e, tbl[i].inc ? tbl[i].idx + k : tbl[i].idx);
            @(posedge clk); #1;
         end
      end

      // Reset applied between edges must take effect without a clock.
      drive(0, 1, 1, 1, 0);
      @(posedge clk); #1;
      drive(0, 0, 0, 1, 0);
      #2;
      check("async_pre", RND|BSY, 0);
      rst = 1'b1;
      #1;
      check("async_rst", '0, 0);
      @(posedge clk); #1;

      // Randomized traffic against the model.
      begin
         bit f, l, rdy, r;
         int ob;
         logic [6:0] e;
         int ei;
         model_reset();
         ob = 1;
         for (int c = 0; c < 4000; c++) begin
            r   = ($urandom_range(0, 299) == 0);
            f   = ($urandom_range(0, 3) != 0);
            l   = $urandom_range(0, 1) == 1;
            rdy = $urandom_range(0, 1) == 1;
            if (!f) ob = $urandom_range(0, 3);
            drive(r, f, l, ob, rdy);
            if (r) model_reset();
            #4;
            model_eval(r, f, rdy, e, ei);
            check("rand", e, ei);
            if (!r) model_step(f, l, ob, rdy);
            @(posedge clk); #1;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
